// File: rtl/rr_fifo_arbiter.sv
// Round-robin arbiter for N head-of-FIFO sources feeding one registered output slot.
// A source may hold the channel for up to BURST consecutive grants before priority rotates.
module rr_fifo_arbiter #(
    parameter  int N     = 4,
    parameter  int WIDTH = 64,
    parameter  int BURST = 1,
    localparam int SRC_W = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W = (BURST > 1) ? $clog2(BURST + 1) : 1
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [N-1:0]         i_Valid,
    input  logic [N*WIDTH-1:0]   i_Data,
    output logic [N-1:0]         o_Grant,
    output logic                 o_Valid,
    output logic [WIDTH-1:0]     o_Data,
    output logic [SRC_W-1:0]     o_Src,
    input  logic                 i_Ready
);

    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [SRC_W-1:0]   src_q,   src_d;
    logic [SRC_W-1:0]   cur_q,   cur_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [WIDTH-1:0]   data_arr [N];
    logic [SRC_W:0]     cand_sum [N];
    logic [SRC_W-1:0]   cand_idx [N];
    logic [N-1:0]       cand_req;

    logic               load;
    logic               grant_en;
    logic               burst_cont;
    logic               scan_hit;
    logic [SRC_W-1:0]   scan_idx;
    logic [SRC_W-1:0]   win_idx;

    // Candidate j of the scan is source (cur+1+j) mod N, so cur itself is checked last.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign data_arr[gi] = i_Data[gi*WIDTH +: WIDTH];
        assign cand_sum[gi] = {1'b0, cur_q} + (SRC_W+1)'(gi + 1);
        assign cand_idx[gi] = (cand_sum[gi] >= (SRC_W+1)'(N))
                            ? SRC_W'(cand_sum[gi] - (SRC_W+1)'(N))
                            : cand_sum[gi][SRC_W-1:0];
        assign cand_req[gi] = i_Valid[cand_idx[gi]];
    end

    always_comb begin
        scan_hit = 1'b0;
        scan_idx = cur_q;
        for (int j = N - 1; j >= 0; j--) begin
            if (cand_req[j]) begin
                scan_hit = 1'b1;
                scan_idx = cand_idx[j];
            end
        end
    end

    assign load       = !valid_q || i_Ready;
    assign burst_cont = (cnt_q != '0) && (cnt_q < CNT_W'(BURST)) && i_Valid[cur_q];
    assign win_idx    = burst_cont ? cur_q : scan_idx;
    // Reset gates the grant so no FIFO pops while the slot is being cleared.
    assign grant_en   = !Reset && load && (burst_cont || scan_hit);

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign o_Grant[gi] = grant_en && (win_idx == SRC_W'(gi));
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        if (grant_en) begin
            valid_d = 1'b1;
            data_d  = data_arr[win_idx];
            src_d   = win_idx;
            cur_d   = win_idx;
            cnt_d   = burst_cont ? (cnt_q + CNT_W'(1)) : CNT_W'(1);
        end else if (load) begin
            valid_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
            cur_q   <= SRC_W'(N - 1);
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_Valid = valid_q;
    assign o_Data  = data_q;
    assign o_Src   = src_q;

endmodule
